// File: rtl/lsu_data_memory.sv
// MEM-stage data memory: byte/half/word loads and stores with a fixed access
// latency that freezes the pipeline, and a registered fault pulse on bad accesses.
module lsu_data_memory #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter int unsigned LATENCY     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_inst,
   input  logic [31:0] exe_result,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_result,
   output logic [31:0] write_back_inst,
   output logic        freeze_cpu,
   output logic        mem_fault
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [7:0]  LAT      = 8'(LATENCY);
   localparam logic [6:0]  OP_LOAD  = 7'b0000011;
   localparam logic [6:0]  OP_STORE = 7'b0100011;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic [31:0]   mem_q [DEPTH_WORDS];
   logic [7:0]    cnt_q, cnt_d;
   logic [31:0]   mem_result_q, mem_result_d;
   logic [31:0]   wb_inst_q, wb_inst_d;
   logic          mem_fault_q, mem_fault_d;

   logic          is_load, is_store, is_ls, fault, wr_en;
   logic [2:0]    funct3;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word, load_data, wdata;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [3:0]    be;
   logic          unused_bits;

   assign funct3      = mem_inst[14:12];
   assign is_load     = (mem_inst[6:0] == OP_LOAD);
   assign is_store    = (mem_inst[6:0] == OP_STORE);
   assign is_ls       = is_load | is_store;
   assign idx         = mem_addr[AW+1:2];
   assign rd_word     = mem_q[idx];
   assign rd_half     = mem_addr[1] ? rd_word[31:16] : rd_word[15:0];
   assign freeze_cpu  = is_ls && (cnt_q != LAT);
   assign wr_en       = is_store && !freeze_cpu && !fault;
   assign unused_bits = ^{mem_inst[31:15], mem_inst[11:7], mem_addr[31:AW+2]};

   always_comb begin
      case (mem_addr[1:0])
         2'd0:    rd_byte = rd_word[7:0];
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
   end

   // Stores only allow B/H/W; loads additionally allow BU/HU.
   always_comb begin
      fault = 1'b0;
      if (is_ls) begin
         case (funct3)
            3'b000:  fault = 1'b0;
            3'b001:  fault = mem_addr[0];
            3'b010:  fault = (mem_addr[1:0] != 2'b00);
            3'b100:  fault = is_store;
            3'b101:  fault = is_store | mem_addr[0];
            default: fault = 1'b1;
         endcase
      end
   end

   always_comb begin
      case (funct3)
         3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  load_data = {24'h0, rd_byte};
         3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
         3'b101:  load_data = {16'h0, rd_half};
         3'b010:  load_data = rd_word;
         default: load_data = '0;
      endcase
   end

   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << mem_addr[1:0];
            wdata = {4{exe_result[7:0]}};
         end
         2'b01: begin
            be    = mem_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{exe_result[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = exe_result;
         end
      endcase
   end

   always_comb begin
      cnt_d        = '0;
      mem_result_d = mem_result_q;
      wb_inst_d    = wb_inst_q;
      mem_fault_d  = 1'b0;
      if (is_ls && cnt_q != LAT) cnt_d = cnt_q + 8'd1;
      if (!freeze_cpu) begin
         wb_inst_d = mem_inst;
         if (!is_ls)        mem_result_d = exe_result;
         else if (fault) begin
            mem_result_d = '0;
            mem_fault_d  = 1'b1;
         end
         else if (is_store) mem_result_d = exe_result;
         else               mem_result_d = load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         mem_result_q <= '0;
         wb_inst_q    <= NOP_INST;
         mem_fault_q  <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         mem_result_q <= mem_result_d;
         wb_inst_q    <= wb_inst_d;
         mem_fault_q  <= mem_fault_d;
      end
   end

   // Storage is deliberately left out of reset; only the write is gated.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign mem_result      = mem_result_q;
   assign write_back_inst = wb_inst_q;
   assign mem_fault       = mem_fault_q;

endmodule

// File: doc/lsu_data_memory.md
LSU_DATA_MEMORY -- requirements
Module: lsu_data_memory

Interface
- REQ-001: Parameter DEPTH_WORDS, default 64, number of 32-bit words; SHALL be a power of two, at least 2.
- REQ-002: Parameter LATENCY, default 4, number of freeze cycles per load/store; SHALL be in the range 0..255.
- REQ-003: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: mem_inst  input  32  instruction held in the MEM stage.
- REQ-006: exe_result  input  32  ALU result, or store data for stores.
- REQ-007: mem_addr  input  32  byte address.
- REQ-008: mem_result  output  32  registered value passed to write-back.
- REQ-009: write_back_inst  output  32  registered instruction passed to write-back.
- REQ-010: freeze_cpu  output  1  combinational pipeline stall.
- REQ-011: mem_fault  output  1  registered, one-cycle pulse flagging a faulting access.

Function
- REQ-012: Load SHALL mean opcode 0000011; store SHALL mean opcode 0100011; funct3 SHALL be mem_inst[14:12].
- REQ-013: Word index SHALL be mem_addr[log2(DEPTH_WORDS)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4.
- REQ-014: Counter cnt SHALL have 8 bits; freeze_cpu SHALL equal (load or store) AND (cnt != LATENCY).
- REQ-015: cnt transitions:
  - cnt is 0 and a load/store is present with LATENCY>0: cnt SHALL go to 1.
  - cnt is 1..LATENCY-1: cnt SHALL increment.
  - cnt equals LATENCY: cnt SHALL return to 0 and the access SHALL execute at that edge.
- REQ-016: With LATENCY=0, every access SHALL complete in one cycle with no freeze.
- REQ-017: While freeze_cpu=1, mem_result and write_back_inst SHALL hold their values and memory SHALL NOT be written.
- REQ-018: When not frozen, write_back_inst SHALL be loaded with mem_inst.
- REQ-019: For a non-load/store, mem_result SHALL be loaded with exe_result every cycle and cnt SHALL stay 0.
- REQ-020: Stores SHALL write only the addressed byte lanes and leave the other lanes unchanged:
  - SB: lane mem_addr[1:0], data exe_result[7:0].
  - SH: lanes {mem_addr[1],0} and {mem_addr[1],1}, data exe_result[15:0].
  - SW: all four lanes.
- REQ-021: Loads SHALL take the addressed byte or halfword and extend it:
  - LB and LH: sign-extend.
  - LBU and LHU: zero-extend.
  - LW: the whole word.
- REQ-022: A store SHALL set mem_result to exe_result.
- REQ-023: A fault is any of:
  - a halfword access with mem_addr[0]=1;
  - a word access with mem_addr[1:0]!=0;
  - a load funct3 in {011,110,111};
  - a store funct3 not in {000,001,010}.
- REQ-024: A faulting access SHALL still take the LATENCY cycles; at completion it SHALL:
  - not write memory;
  - set mem_result to 0;
  - pulse mem_fault for one cycle.
- REQ-025: If mem_inst changes while cnt>0, the count SHALL continue and the completing access SHALL use the mem_inst, mem_addr and exe_result present at the completion cycle.
- REQ-026: A load in the cycle after a store to the same word SHALL return the stored data.

Reset
- REQ-027: When rst=1 at a clock edge:
  - cnt SHALL become 0;
  - mem_result SHALL become 0;
  - write_back_inst SHALL become 0x00000013 (NOP);
  - mem_fault SHALL become 0.
- REQ-028: Reset during an access SHALL abandon it with no memory write; freeze_cpu SHALL then follow REQ-014 using cnt=0.
- REQ-029: Memory contents SHALL NOT be affected by reset.

Verification
- REQ-030: Store then load, LATENCY=4: SW 0x80402010 to address 0x0, then LW from 0x0 -> freeze_cpu high for 4 cycles per access, and mem_result=0x80402010 on the cycle after the load releases.
- REQ-031: Byte lanes: after the REQ-030 word, SB 0xFF to address 0x2, then LW from 0x0 -> 0x80FF2010; LB from 0x3 -> 0xFFFFFF80; LBU from 0x3 -> 0x00000080.
- REQ-032: Halfword: SH 0x8001 to address 0x6, then LH from 0x6 -> 0xFFFF8001; LHU from 0x6 -> 0x00008001.
- REQ-033: Faults: LW from 0x5 and SH to 0x3 -> each gives a mem_fault pulse, mem_result=0, and memory unchanged.
- REQ-034: Reset mid-access: assert rst at cnt=2 of an SW -> target word unchanged, mem_result=0, write_back_inst=0x00000013.
- REQ-035: LATENCY=0, DEPTH_WORDS=16: a back-to-back SW/LW pair -> freeze_cpu never high; address 0x40 aliases to 0x0.
